pdm_cic_decimator: RTL and testbench

//   PDM-to-PCM decoder: the receiving end of the 1-bit sigma-delta DAC link (SDM1st).

---
 rtl/pdm_cic_decimator.sv | 73 +++++++
 tb/tb_pdm_cic_decimator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: 2nd-order CIC decimator turning a 1-bit PDM stream into unsigned N-bit PCM
module pdm_cic_decimator #(
    parameter int N     = 16,
    parameter int LOG2R = 5
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         pdm_en,
    input  logic         pdm,
    output logic [N-1:0] dout,
    output logic         dout_valid
);
    localparam int W  = 2*LOG2R+1;
    localparam int SH = N-2*LOG2R;

    logic [W-1:0]     int1_q, int1_d, int2_q, int2_d, xd_q, xd_d, c1d_q, c1d_d;
    logic [LOG2R-1:0] cnt_q, cnt_d;
    logic             dec_q, dec_d, valid_q, valid_d;
    logic [N-1:0]     dout_q, dout_d;
    logic [W-1:0]     c1, c2;
    logic [N:0]       wide;

    // Integrators and bit counter advance only on accepted bits; wrap-around is intended
    always_comb begin
        int1_d = int1_q;
        int2_d = int2_q;
        cnt_d  = cnt_q;
        dec_d  = 1'b0;
        if (pdm_en) begin
            int1_d = int1_q + W'(pdm);
            int2_d = int2_q + int1_d;
            cnt_d  = cnt_q + LOG2R'(1);
            dec_d  = &cnt_q;
        end
    end

    // Comb section runs one edge after the last bit of a frame and produces the saturated sample
    always_comb begin
        c1      = int2_q - xd_q;
        c2      = c1 - c1d_q;
        wide    = (N+1)'(c2) << SH;
        xd_d    = dec_q ? int2_q : xd_q;
        c1d_d   = dec_q ? c1 : c1d_q;
        dout_d  = dec_q ? (wide[N] ? {N{1'b1}} : wide[N-1:0]) : dout_q;
        valid_d = dec_q;
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            int1_q  <= '0;
            int2_q  <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            xd_q    <= '0;
            c1d_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            int1_q  <= int1_d;
            int2_q  <= int2_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            xd_q    <= xd_d;
            c1d_q   <= c1d_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: directed self-checking bench for the PDM CIC decimator
module tb_pdm_cic_decimator;
    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        pdm_en = 1'b0;
    logic        pdm = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vq[$];
    int cq[$];

    pdm_cic_decimator #(.N(16), .LOG2R(5)) dut (
        .clk(clk), .areset(areset), .pdm_en(pdm_en), .pdm(pdm),
        .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input logic en, input logic b);
        pdm_en = en;
        pdm = b;
        @(posedge clk);
        #1;
        cyc++;
        if (dout_valid) begin
            vq.push_back(int'(dout));
            cq.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        vq.delete();
        cq.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        areset = 1'b0;
        pdm_en = 1'b0;
        #3;
        areset = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        areset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pdm = 1'($urandom);
            pdm_en = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (dout !== 16'd0 || dout_valid !== 1'b0)
                begin errors++; $display("FAIL reset_out dout=%0d valid=%0b want 0/0", dout, dout_valid); end
        end
        areset = 1'b1;
        clear_log();
        for (int i = 0; i < 1000; i++) step(1'b0, 1'($urandom));
        checks++;
        if (vq.size() != 0)
            begin errors++; $display("FAIL idle_valid got %0d pulses want 0", vq.size()); end
        checks++;
        if (dout !== 16'd0)
            begin errors++; $display("FAIL idle_dout got %0d want 0", dout); end
    endtask

    task automatic test_all_ones();
        int held;
        do_reset();
        for (int i = 0; i < 20000; i++) step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        checks++;
        if (vq.size() != 625)
            begin errors++; $display("FAIL ones_count got %0d want 625", vq.size()); end
        checks++;
        if (cq.size() < 1 || cq[0] != 33)
            begin errors++; $display("FAIL ones_latency got %0d want 33", cq.size() ? cq[0] : -1); end
        foreach (vq[i]) begin
            checks++;
            if (vq[i] != (i == 0 ? 33792 : 65535))
                begin errors++; $display("FAIL ones_dout[%0d] got %0d want %0d", i, vq[i], i == 0 ? 33792 : 65535); end
            if (i > 0) begin
                checks++;
                if (cq[i] - cq[i-1] != 32)
                    begin errors++; $display("FAIL ones_period[%0d] got %0d want 32", i, cq[i] - cq[i-1]); end
            end
        end
        held = int'(dout);
        clear_log();
        for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom));
        checks++;
        if (vq.size() != 0 || int'(dout) != held || held != 65535)
            begin errors++; $display("FAIL hold got pulses=%0d dout=%0d want 0/65535", vq.size(), dout); end
    endtask

    task automatic test_all_zeros();
        do_reset();
        for (int i = 0; i < 640; i++) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        checks++;
        if (vq.size() != 20)
            begin errors++; $display("FAIL zeros_count got %0d want 20", vq.size()); end
        foreach (vq[i]) begin
            checks++;
            if (vq[i] != 0)
                begin errors++; $display("FAIL zeros_dout[%0d] got %0d want 0", i, vq[i]); end
            if (i > 0) begin
                checks++;
                if (cq[i] - cq[i-1] != 32)
                    begin errors++; $display("FAIL zeros_period[%0d] got %0d want 32", i, cq[i] - cq[i-1]); end
            end
        end
    endtask

    task automatic test_alternating();
        do_reset();
        for (int k = 0; k < 640; k++) begin
            step(1'b1, k % 2 == 0);
            step(1'b0, 1'b0);
        end
        repeat (2) step(1'b0, 1'b0);
        checks++;
        if (vq.size() != 20)
            begin errors++; $display("FAIL alt_count got %0d want 20", vq.size()); end
        checks++;
        if (cq.size() < 1 || cq[0] != 64)
            begin errors++; $display("FAIL alt_latency got %0d want 64", cq.size() ? cq[0] : -1); end
        foreach (vq[i]) begin
            checks++;
            if (vq[i] != (i == 0 ? 17408 : 32768))
                begin errors++; $display("FAIL alt_dout[%0d] got %0d want %0d", i, vq[i], i == 0 ? 17408 : 32768); end
            if (i > 0) begin
                checks++;
                if (cq[i] - cq[i-1] != 64)
                    begin errors++; $display("FAIL alt_period[%0d] got %0d want 64", i, cq[i] - cq[i-1]); end
            end
        end
    endtask

    task automatic run_sdm(input logic [15:0] din, input int target);
        logic [15:0] acc;
        logic [16:0] s;
        int d;
        acc = 16'd0;
        clear_log();
        for (int k = 0; k < 1280; k++) begin
            s = {1'b0, acc} + {1'b0, din};
            acc = s[15:0];
            step(1'b1, s[16]);
            step(1'b0, 1'b0);
        end
        checks++;
        if (vq.size() != 40)
            begin errors++; $display("FAIL sdm_count din=%h got %0d want 40", din, vq.size()); end
        for (int i = 30; i < vq.size(); i++) begin
            d = vq[i] - target;
            checks++;
            if (d < -64 || d > 64)
                begin errors++; $display("FAIL sdm_dout[%0d] din=%h got %0d want %0d+-64", i, din, vq[i], target); end
        end
    endtask

    task automatic test_loopback();
        do_reset();
        run_sdm(16'h4000, 16384);
        run_sdm(16'hC000, 49152);
    endtask

    task automatic test_midframe_reset();
        do_reset();
        for (int i = 0; i < 81; i++) step(1'b1, 1'b1);
        checks++;
        if (vq.size() != 2 || int'(dout) != 65535)
            begin errors++; $display("FAIL mid_pre got n=%0d dout=%0d want 2/65535", vq.size(), dout); end
        areset = 1'b0;
        #2;
        checks++;
        if (dout !== 16'd0 || dout_valid !== 1'b0)
            begin errors++; $display("FAIL mid_async got dout=%0d valid=%0b want 0/0", dout, dout_valid); end
        #2;
        areset = 1'b1;
        clear_log();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        checks++;
        if (vq.size() != 1)
            begin errors++; $display("FAIL mid_count got %0d want 1", vq.size()); end
        checks++;
        if (vq.size() < 1 || cq[0] != 33 || vq[0] != 33792)
            begin errors++; $display("FAIL mid_restart got cyc=%0d dout=%0d want 33/33792", cq.size() ? cq[0] : -1, vq.size() ? vq[0] : -1); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_alternating();
        test_loopback();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
